thresholding_axilite_loader: RTL
================================

Name: thresholding_axilite_loader

Overview:
- AXI-Lite write initiator that programs the threshold memory of a thresholding_axi core at run time.
- Consumes a stream of threshold values in channel-major order: channel c = 0..C-1, threshold t = 0..2^N-2.
- Issues one AXI-Lite write per threshold to the core's address map and reports completion and error status.
- Sits between a DMA or host stream and the core's s_axilite port.

Parameters:
- N, 4, output precision of the target core; each channel has 2^N-1 thresholds.
- K, 8, threshold precision in bits (1..32).
- C, 16, number of channels.
- PE, 4, processing parallelism of the target; C mod PE = 0.
- SIGNED, 1, sign-extend thresholds to 32 bits if 1, else zero-extend.
- localparam CF = C/PE.
- localparam ADDR_BITS = $clog2(CF)+$clog2(PE)+N+2.
- localparam TW = ((K+7)/8)*8.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a full load; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last B response.
- err  out  1  sticky; set on any BRESP != 0; cleared by the next accepted start.
- s_axis_tready  out  1  threshold stream ready.
- s_axis_tvalid  in  1  threshold stream valid.
- s_axis_tdata  in  TW  threshold value in bits [K-1:0]; upper bits ignored.
- m_axilite_AWVALID  out  1  write address valid.
- m_axilite_AWREADY  in  1  write address ready.
- m_axilite_AWADDR  out  ADDR_BITS  byte address.
- m_axilite_WVALID  out  1  write data valid.
- m_axilite_WREADY  in  1  write data ready.
- m_axilite_WDATA  out  32  extended threshold.
- m_axilite_WSTRB  out  4  constant 4'hF.
- m_axilite_BVALID  in  1  write response valid.
- m_axilite_BREADY  out  1  write response ready.
- m_axilite_BRESP  in  2  write response code.

Behaviour:
- Reset values: all outputs 0 except WSTRB = 4'hF; counters 0; state IDLE; err 0.
- Reset asserted mid-transaction aborts immediately. No further AXI activity until the next start.
- Address mapping: word index = (cf << ($clog2(PE)+N)) | (pe << N) | t, where c = cf*PE + pe.
  - AWADDR = word index << 2.
  - Slot t = 2^N-1 is never written.
- Counters: t wraps at 2^N-2 and then increments pe. pe wraps at PE-1 and then increments cf. last = (cf = CF-1) & (pe = PE-1) & (t = 2^N-2).
- FSM:
  - IDLE: start -> FETCH; clears err and counters.
  - FETCH: s_axis_tready = 1. On tvalid, latch the extended data and address -> ISSUE.
  - ISSUE: AWVALID and WVALID both rise together.
    - Each drops independently in the cycle after its own ready handshake; AW and W may complete in either order.
    - When both are done -> WAIT_B.
    - Address and data must stay stable while their valid is high.
  - WAIT_B: BREADY = 1. On BVALID: err |= (BRESP != 0). If last -> IDLE with done = 1 for one cycle; else advance counters -> FETCH.
- At most one outstanding write. Minimum 3 cycles per threshold when AWREADY, WREADY and BVALID are immediate.
- An error response does not abort the load; the remaining writes continue.
- Stream data arriving outside FETCH is back-pressured; s_axis_tready is never high in any other state.
- A start that arrives in the same cycle as a done pulse is ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package thresholding_pkg:
  - address-composition function addr_of(cf, pe, t) parameterised by N and PE, shared with the core's decoder;
  - AXI response code constants OKAY, SLVERR, DECERR;
  - loader state enum.
- One sub-module, thresholding_loader_addr_gen: holds the t/pe/cf counters, produces AWADDR and last, advances on a step input.

Test Plan:
- N=2, K=8, C=4, PE=2, slave always ready, stream 0x01..0x0C -> exactly 12 writes.
  - AWADDR sequence 0x00,0x04,0x08,0x10,0x14,0x18,0x20,0x24,0x28,0x30,0x34,0x38.
  - One done pulse; err = 0.
  - Minimum 36 cycles from FETCH entry to done.
- SIGNED=1, tdata 0x80 -> WDATA 0xFFFFFF80. SIGNED=0, tdata 0x80 -> WDATA 0x00000080.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held with stable AWADDR until accepted, then BREADY asserted.
- BRESP = 2'b10 on the 5th write -> err set and held; all 12 writes still issued; done pulses. Next start clears err.
- Assert ap_rst_n low while in WAIT_B -> all valids, busy and done read 0 immediately. After release, a new start begins again at AWADDR 0x00.
- start pulsed while busy -> no effect on counters or sequence; s_axis_tvalid held high in WAIT_B -> tready stays 0.

Source files
------------

// File: rtl/thresholding_pkg.sv
// thresholding_pkg: address map, AXI response codes and loader states shared by
// the threshold loader and the core's decoder.
package thresholding_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_IDLE   = 2'd0;
  localparam loader_state_t ST_FETCH  = 2'd1;
  localparam loader_state_t ST_ISSUE  = 2'd2;
  localparam loader_state_t ST_WAIT_B = 2'd3;

  // Byte address of threshold t of channel cf*PE+pe; pe_bits = $clog2(PE).
  function automatic logic [31:0] addr_of(
    input int unsigned n,
    input int unsigned pe_bits,
    input logic [31:0] cf,
    input logic [31:0] pe,
    input logic [31:0] t
  );
    return ((cf << (pe_bits + n)) | (pe << n) | t) << 2;
  endfunction

endpackage

// File: rtl/thresholding_loader_addr_gen.sv
// thresholding_loader_addr_gen: t/pe/cf walk over the threshold map, yielding
// the current write address and the last-threshold flag.
module thresholding_loader_addr_gen
  import thresholding_pkg::*;
#(
  parameter int N  = 4,
  parameter int C  = 16,
  parameter int PE = 4,
  localparam int CF        = C / PE,
  localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  input  logic                 step,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last
);

  localparam int PEW = (PE > 1) ? $clog2(PE) : 1;
  localparam int CFW = (CF > 1) ? $clog2(CF) : 1;
  localparam logic [N-1:0]   T_MAX  = N'(2 ** N - 2);
  localparam logic [PEW-1:0] PE_MAX = PEW'(PE - 1);
  localparam logic [CFW-1:0] CF_MAX = CFW'(CF - 1);

  logic [N-1:0]   t_q, t_d;
  logic [PEW-1:0] pe_q, pe_d;
  logic [CFW-1:0] cf_q, cf_d;
  logic           t_wrap, pe_wrap, cf_wrap;

  always_comb begin
    t_wrap  = t_q == T_MAX;
    pe_wrap = pe_q == PE_MAX;
    cf_wrap = cf_q == CF_MAX;
    t_d  = clr ? '0 : step ? (t_wrap ? '0 : t_q + 1'b1) : t_q;
    pe_d = clr ? '0 : (step && t_wrap) ? (pe_wrap ? '0 : pe_q + 1'b1) : pe_q;
    cf_d = clr ? '0 : (step && t_wrap && pe_wrap) ? (cf_wrap ? '0 : cf_q + 1'b1) : cf_q;
    addr = ADDR_BITS'(addr_of(N, $clog2(PE), 32'(cf_q), 32'(pe_q), 32'(t_q)));
    last = t_wrap && pe_wrap && cf_wrap;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      t_q  <= '0;
      pe_q <= '0;
      cf_q <= '0;
    end else begin
      t_q  <= t_d;
      pe_q <= pe_d;
      cf_q <= cf_d;
    end
  end

endmodule

// File: rtl/thresholding_axilite_loader.sv
// thresholding_axilite_loader: turns a channel-major threshold stream into one
// AXI-Lite write per threshold into a thresholding_axi core's memory.
module thresholding_axilite_loader
  import thresholding_pkg::*;
#(
  parameter int N      = 4,
  parameter int K      = 8,
  parameter int C      = 16,
  parameter int PE     = 4,
  parameter int SIGNED = 1,
  localparam int CF        = C / PE,
  localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2,
  localparam int TW        = ((K + 7) / 8) * 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tvalid,
  input  logic [TW-1:0]        s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP
);

  loader_state_t state_q, state_d;
  logic          aw_q, aw_d, w_q, w_d;
  logic          done_q, done_d, err_q, err_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [K-1:0]  tval;
  logic [31:0]   ext;
  logic          clr, step, last;

  // Counters only move in IDLE (clear) and WAIT_B (step), so the address is
  // stable for the whole ISSUE phase without a separate latch.
  thresholding_loader_addr_gen #(.N(N), .C(C), .PE(PE)) u_addr_gen (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (clr),
    .step     (step),
    .addr     (m_axilite_AWADDR),
    .last     (last)
  );

  always_comb begin
    tval    = s_axis_tdata[K-1:0];
    ext     = (SIGNED != 0) ? 32'(signed'(tval)) : 32'(tval);
    state_d = state_q;
    aw_d    = aw_q;
    w_d     = w_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: if (start && !done_q) begin
        state_d = ST_FETCH;
        err_d   = 1'b0;
        clr     = 1'b1;
      end
      ST_FETCH: if (s_axis_tvalid) begin
        state_d = ST_ISSUE;
        wdata_d = ext;
        aw_d    = 1'b1;
        w_d     = 1'b1;
      end
      ST_ISSUE: begin
        aw_d    = aw_q && !m_axilite_AWREADY;
        w_d     = w_q && !m_axilite_WREADY;
        state_d = (!aw_d && !w_d) ? ST_WAIT_B : ST_ISSUE;
      end
      default: if (m_axilite_BVALID) begin
        err_d   = err_q || (m_axilite_BRESP != OKAY);
        done_d  = last;
        step    = !last;
        state_d = last ? ST_IDLE : ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy              = state_q != ST_IDLE;
  assign done              = done_q;
  assign err               = err_q;
  assign s_axis_tready     = state_q == ST_FETCH;
  assign m_axilite_AWVALID = aw_q;
  assign m_axilite_WVALID  = w_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = state_q == ST_WAIT_B;

endmodule
